// File: rtl/button_pkg.sv
// Shared types and helpers for the multi-channel button debouncer.
package button_pkg;

    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button bundle between pad-side logic and the debouncer.
interface button_debouncer_if #(
    parameter int WIDTH = 1
);

    logic [WIDTH-1:0] btn_raw;
    logic [WIDTH-1:0] btn_clean;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [WIDTH-1:0] busy;

    modport master (
        output btn_raw,
        input  btn_clean,
        input  rise_pulse,
        input  fall_pulse,
        input  busy
    );

    modport slave (
        input  btn_raw,
        output btn_clean,
        output rise_pulse,
        output fall_pulse,
        output busy
    );

endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: 2-FF synchroniser, stability counter, edge pulses.
module debounce_channel
    import button_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
);

    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic          r_s1;
    logic          r_s2;
    logic          r_clean;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    state_e        w_state;
    logic          w_diff;
    logic          w_accept;
    logic [CW-1:0] w_cnt_nxt;

    assign w_state = (r_cnt != '0) ? ST_COUNTING : ST_STABLE;
    assign w_diff  = r_s2 ^ r_clean;

    // Any sample that agrees with the clean level restarts the count.
    always_comb begin
        w_accept  = 1'b0;
        w_cnt_nxt = '0;
        unique case (w_state)
            ST_STABLE: begin
                if (w_diff) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_accept = 1'b1;
                    end else begin
                        w_cnt_nxt = ONE;
                    end
                end
            end
            ST_COUNTING: begin
                if (w_diff) begin
                    if (r_cnt == LAST) begin
                        w_accept = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + ONE;
                    end
                end
            end
            default: begin
                w_accept  = 1'b0;
                w_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1    <= IDLE_LEVEL;
            r_s2    <= IDLE_LEVEL;
            r_clean <= IDLE_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1   <= i_raw;
            r_s2   <= r_s1;
            r_cnt  <= w_cnt_nxt;
            r_rise <= w_accept & r_s2;
            r_fall <= w_accept & ~r_s2;
            if (w_accept) begin
                r_clean <= r_s2;
            end
        end
    end

    assign o_clean = r_clean;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_busy  = (r_cnt != '0);

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button conditioner feeding the PIO in_port plus edge strobes.
module button_debouncer
    import button_pkg::*;
#(
    parameter int   WIDTH           = 1,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input logic               clk,
    input logic               reset_n,
    button_debouncer_if.slave bus
);

    logic [WIDTH-1:0] w_clean;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_busy;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .i_raw   (bus.btn_raw[g]),
            .o_clean (w_clean[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g]),
            .o_busy  (w_busy[g])
        );
    end

    assign bus.btn_clean  = w_clean;
    assign bus.rise_pulse = w_rise;
    assign bus.fall_pulse = w_fall;
    assign bus.busy       = w_busy;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: DEBOUNCE_CYCLES=4 and =1 builds, WIDTH=2, idle-high keys.
module tb_button_debouncer;

    typedef struct {
        int         cyc;
        logic [1:0] clean;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] busy;
        string      name;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   base    = 0;
    int   total   = 0;
    int   bad     = 0;
    bit   hit0;
    bit   hit1;
    exp_t q0[$];
    exp_t q1[$];

    button_debouncer_if #(.WIDTH(2)) bus0 ();
    button_debouncer_if #(.WIDTH(2)) bus1 ();

    button_debouncer #(
        .WIDTH           (2),
        .DEBOUNCE_CYCLES (4),
        .IDLE_LEVEL      (1'b1)
    ) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    button_debouncer #(
        .WIDTH           (2),
        .DEBOUNCE_CYCLES (1),
        .IDLE_LEVEL      (1'b1)
    ) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // k = sampling edge index after the stimulus change; k=-1 means now
    task automatic push(input int u, input int k,
                        input logic [1:0] c, input logic [1:0] r,
                        input logic [1:0] f, input logic [1:0] b,
                        input string n);
        exp_t e;
        e.cyc   = base + 1 + k;
        e.clean = c;
        e.rise  = r;
        e.fall  = f;
        e.busy  = b;
        e.name  = n;
        if (u == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic cmp(input string n, input string f,
                       input logic [1:0] a, input logic [1:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s.%s cyc=%0d got=%b want=%b", n, f, cyc, a, e);
        end
    endtask

    task automatic check_rec(input exp_t e,
                             input logic [1:0] c, input logic [1:0] r,
                             input logic [1:0] f, input logic [1:0] b);
        cmp(e.name, "clean", c, e.clean);
        cmp(e.name, "rise", r, e.rise);
        cmp(e.name, "fall", f, e.fall);
        cmp(e.name, "busy", b, e.busy);
    endtask

    always @(negedge clk) begin
        #1;
        hit0 = 1'b0;
        while (q0.size() > 0 && q0[0].cyc <= cyc) begin
            if (q0[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL %s stale cyc=%0d want_cyc=%0d",
                         q0[0].name, cyc, q0[0].cyc);
            end else begin
                check_rec(q0[0], bus0.btn_clean, bus0.rise_pulse,
                          bus0.fall_pulse, bus0.busy);
                hit0 = 1'b1;
            end
            void'(q0.pop_front());
        end
        if (!hit0)
            cmp("idle0", "pulses", bus0.rise_pulse | bus0.fall_pulse, 2'b00);
        hit1 = 1'b0;
        while (q1.size() > 0 && q1[0].cyc <= cyc) begin
            if (q1[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL %s stale cyc=%0d want_cyc=%0d",
                         q1[0].name, cyc, q1[0].cyc);
            end else begin
                check_rec(q1[0], bus1.btn_clean, bus1.rise_pulse,
                          bus1.fall_pulse, bus1.busy);
                hit1 = 1'b1;
            end
            void'(q1.pop_front());
        end
        if (!hit1)
            cmp("idle1", "pulses", bus1.rise_pulse | bus1.fall_pulse, 2'b00);
    end

    initial begin
        bus0.btn_raw = 2'b11;
        bus1.btn_raw = 2'b11;
        reset_n      = 1'b0;
        repeat (3) @(negedge clk);

        // reset hold and 20 quiet cycles after release
        base = cyc;
        push(0, -1, 2'b11, 2'b00, 2'b00, 2'b00, "rst_hold0");
        push(1, -1, 2'b11, 2'b00, 2'b00, 2'b00, "rst_hold1");
        @(negedge clk);
        base    = cyc;
        reset_n = 1'b1;
        for (int k = -1; k < 19; k++)
            push(0, k, 2'b11, 2'b00, 2'b00, 2'b00, "post_rst");
        repeat (20) @(negedge clk);

        // clean press on channel 0
        base = cyc;
        bus0.btn_raw = 2'b10;
        for (int k = 0; k <= 6; k++)
            push(0, k, (k >= 5) ? 2'b10 : 2'b11, 2'b00,
                 (k == 5) ? 2'b01 : 2'b00,
                 (k >= 2 && k <= 4) ? 2'b01 : 2'b00, "press");
        repeat (8) @(negedge clk);

        // release channel 0
        base = cyc;
        bus0.btn_raw = 2'b11;
        for (int k = 0; k <= 6; k++)
            push(0, k, (k >= 5) ? 2'b11 : 2'b10,
                 (k == 5) ? 2'b01 : 2'b00, 2'b00,
                 (k >= 2 && k <= 4) ? 2'b01 : 2'b00, "release");
        repeat (8) @(negedge clk);

        // three-cycle bounce is rejected
        base = cyc;
        bus0.btn_raw = 2'b10;
        for (int k = 0; k <= 8; k++)
            push(0, k, 2'b11, 2'b00, 2'b00,
                 (k >= 2 && k <= 4) ? 2'b01 : 2'b00, "bounce");
        repeat (3) @(negedge clk);
        bus0.btn_raw = 2'b11;
        repeat (7) @(negedge clk);

        // both channels pressed, then released on the same edge
        base = cyc;
        bus0.btn_raw = 2'b00;
        for (int k = 0; k <= 6; k++)
            push(0, k, (k >= 5) ? 2'b00 : 2'b11, 2'b00,
                 (k == 5) ? 2'b11 : 2'b00,
                 (k >= 2 && k <= 4) ? 2'b11 : 2'b00, "both_press");
        repeat (8) @(negedge clk);
        base = cyc;
        bus0.btn_raw = 2'b11;
        for (int k = 0; k <= 6; k++)
            push(0, k, (k >= 5) ? 2'b11 : 2'b00,
                 (k == 5) ? 2'b11 : 2'b00, 2'b00,
                 (k >= 2 && k <= 4) ? 2'b11 : 2'b00, "both_rel");
        repeat (8) @(negedge clk);

        // reset asserted mid-count, raw held low through it
        base = cyc;
        bus0.btn_raw = 2'b00;
        for (int k = 0; k <= 2; k++)
            push(0, k, 2'b11, 2'b00, 2'b00,
                 (k == 2) ? 2'b11 : 2'b00, "pre_midrst");
        repeat (4) @(negedge clk);
        base    = cyc;
        reset_n = 1'b0;
        push(0, -1, 2'b11, 2'b00, 2'b00, 2'b00, "mid_rst");
        push(0, 0, 2'b11, 2'b00, 2'b00, 2'b00, "mid_rst");
        repeat (2) @(negedge clk);
        base    = cyc;
        reset_n = 1'b1;
        for (int k = 0; k <= 6; k++)
            push(0, k, (k >= 5) ? 2'b00 : 2'b11, 2'b00,
                 (k == 5) ? 2'b11 : 2'b00,
                 (k >= 2 && k <= 4) ? 2'b11 : 2'b00, "after_rst");
        repeat (8) @(negedge clk);
        base = cyc;
        bus0.btn_raw = 2'b11;
        push(0, 5, 2'b11, 2'b11, 2'b00, 2'b00, "restore");
        repeat (8) @(negedge clk);

        // single-cycle acceptance build
        base = cyc;
        bus1.btn_raw = 2'b10;
        for (int k = 0; k <= 3; k++)
            push(1, k, (k >= 2) ? 2'b10 : 2'b11, 2'b00,
                 (k == 2) ? 2'b01 : 2'b00, 2'b00, "dc1_press");
        repeat (5) @(negedge clk);
        base = cyc;
        bus1.btn_raw = 2'b11;
        for (int k = 0; k <= 3; k++)
            push(1, k, (k >= 2) ? 2'b11 : 2'b10,
                 (k == 2) ? 2'b01 : 2'b00, 2'b00, 2'b00, "dc1_rel");
        repeat (6) @(negedge clk);

        total++;
        if (q0.size() + q1.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", q0.size() + q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
